uart_rx_core: RTL and testbench

// - UART serial receiver; consumes the 16x-oversample rx tick strobe from the UART clock generator.
// - Detects the start bit, samples each bit mid-cell and deserialises LSB-first frames.
// - Presents each received byte with a 1-cycle valid strobe plus framing and parity error flags.
// - Counterpart of the UART transmitter; sits between the clock generator and the host/FIFO side.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_2ff.sv | 22 ++
 rtl/uart_rx_core.sv | 147 ++++++++++++++
 tb/tb_uart_rx_core.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Standard baud rates supported by the clock generator
    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;
    localparam int unsigned BAUD_38400 = 38400;
    localparam int unsigned BAUD_57600 = 57600;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages come out of reset at line-idle (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start detection, mid-cell sampling, LSB-first deserialisation,
// framing and parity checking, one-clock valid strobe per received frame.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned SAMPLE_POINT = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_SAMPLE = TICK_W'(SAMPLE_POINT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_BITS - 1);
    localparam logic              ODD_BIT     = (PARITY_ODD != 0);
    localparam logic              PAR_ON      = (PARITY_EN != 0);

    rx_state_e             state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  pbit;
    logic                  armed;
    logic                  rxs;

    logic                  cell_end_c;
    logic [TICK_W-1:0]     tick_next_c;
    logic                  parity_bad_c;

    uart_sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    // Cell-position decode and parity evaluation over captured data + parity bit
    always_comb begin
        cell_end_c   = (tick_cnt == TICK_LAST);
        tick_next_c  = cell_end_c ? '0 : tick_cnt + TICK_W'(1);
        parity_bad_c = PAR_ON && ((^{shreg, pbit}) != ODD_BIT);
    end

    // Frame FSM: advances only on rx_tick; outputs registered, valid strobe lasts one clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            pbit       <= 1'b0;
            armed      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_tick) begin
                // Line seen high: a following falling edge is a genuine start
                if (rxs) begin
                    armed <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (!rxs && armed) begin
                            state   <= START;
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == TICK_SAMPLE) begin
                            // Re-centre: subsequent samples land mid-cell
                            tick_cnt <= '0;
                            if (rxs) begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_next_c;
                        end
                    end
                    DATA: begin
                        tick_cnt <= tick_next_c;
                        if (cell_end_c) begin
                            shreg[bit_idx] <= rxs;
                            bit_idx        <= bit_idx + BIT_W'(1);
                            if (bit_idx == BIT_LAST) begin
                                bit_idx <= '0;
                                if (PAR_ON) begin
                                    state <= PARITY;
                                end else begin
                                    state <= STOP;
                                    armed <= 1'b0;
                                end
                            end
                        end
                    end
                    PARITY: begin
                        tick_cnt <= tick_next_c;
                        if (cell_end_c) begin
                            pbit  <= rxs;
                            state <= STOP;
                            armed <= 1'b0;
                        end
                    end
                    STOP: begin
                        tick_cnt <= tick_next_c;
                        if (cell_end_c) begin
                            rx_data    <= shreg;
                            rx_valid   <= 1'b1;
                            frame_err  <= ~rxs;
                            parity_err <= parity_bad_c;
                            state      <= IDLE;
                            rx_busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8N1 instance and an 8E1 instance share clk/reset/tick.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned OVS      = 16;
    localparam int unsigned BIT_CLK  = TICK_DIV * OVS;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;

    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       frame_err, frame_err_p;
    logic       parity_err, parity_err_p;
    logic       rx_busy, rx_busy_p;

    exp_t       q_a[$];
    exp_t       q_p[$];
    int         total = 0;
    int         bad = 0;
    int         n_valid_a = 0;
    int         n_valid_p = 0;
    int         tick_div_cnt = 0;

    uart_rx_core u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_tick    (rx_tick),
        .rx         (rx_p),
        .rx_data    (rx_data_p),
        .rx_valid   (rx_valid_p),
        .frame_err  (frame_err_p),
        .parity_err (parity_err_p),
        .rx_busy    (rx_busy_p)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (tick_div_cnt == int'(TICK_DIV) - 1) begin
            tick_div_cnt <= 0;
            rx_tick      <= 1'b1;
        end else begin
            tick_div_cnt <= tick_div_cnt + 1;
            rx_tick      <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 8N1 instance
    always @(negedge clk) begin
        if (rx_valid) begin
            exp_t e;
            n_valid_a++;
            check("a_expected_frame_pending", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_rx_data", 32'(rx_data), 32'(e.data));
                check("a_frame_err", 32'(frame_err), 32'(e.ferr));
                check("a_parity_err", 32'(parity_err), 32'(e.perr));
            end
        end
    end

    // Monitor for the even-parity instance
    always @(negedge clk) begin
        if (rx_valid_p) begin
            exp_t e;
            n_valid_p++;
            check("p_expected_frame_pending", 32'(q_p.size() != 0), 32'd1);
            if (q_p.size() != 0) begin
                e = q_p.pop_front();
                check("p_rx_data", 32'(rx_data_p), 32'(e.data));
                check("p_frame_err", 32'(frame_err_p), 32'(e.ferr));
                check("p_parity_err", 32'(parity_err_p), 32'(e.perr));
            end
        end
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit which, input logic v, input int unsigned clks);
        @(negedge clk);
        if (which) rx_p = v;
        else       rx   = v;
        wait_clks(clks - 1);
    endtask

    // pbit < 0: no parity bit on the wire
    task automatic send(input bit which, input logic [7:0] d, input int pbit, input logic stop);
        drive(which, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(which, d[i], BIT_CLK);
        if (pbit >= 0) drive(which, pbit[0], BIT_CLK);
        drive(which, stop, BIT_CLK);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset values
        wait_clks(5);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_rx_busy", 32'(rx_busy), 32'h0);
        check("reset_rx_busy_p", 32'(rx_busy_p), 32'h0);
        rst_n = 1'b1;
        wait_clks(BIT_CLK);

        // 8N1 0xA5
        q_a.push_back('{data: 8'hA5, ferr: 1'b0, perr: 1'b0});
        send(1'b0, 8'hA5, -1, 1'b1);
        wait_clks(BIT_CLK);
        check("a5_valid_count", 32'(n_valid_a), 32'd1);

        // Start glitch: 4 ticks low
        base = n_valid_a;
        drive(1'b0, 1'b0, 3 * TICK_DIV);
        check("glitch_busy_high", 32'(rx_busy), 32'd1);
        drive(1'b0, 1'b0, TICK_DIV);
        drive(1'b0, 1'b1, 2 * BIT_CLK);
        check("glitch_busy_dropped", 32'(rx_busy), 32'd0);
        check("glitch_no_valid", 32'(n_valid_a - base), 32'd0);
        check("glitch_data_held", 32'(rx_data), 32'hA5);

        // 0x3C with a zero stop bit and a 3-cell break
        q_a.push_back('{data: 8'h3C, ferr: 1'b1, perr: 1'b0});
        send(1'b0, 8'h3C, -1, 1'b0);
        drive(1'b0, 1'b0, 3 * BIT_CLK);
        check("break_busy_idle", 32'(rx_busy), 32'd0);
        check("break_frame_err_held", 32'(frame_err), 32'd1);
        check("break_single_frame", 32'(n_valid_a), 32'd2);
        drive(1'b0, 1'b1, BIT_CLK);
        q_a.push_back('{data: 8'h11, ferr: 1'b0, perr: 1'b0});
        send(1'b0, 8'h11, -1, 1'b1);
        wait_clks(BIT_CLK);

        // Even parity: correct then wrong parity bit
        q_p.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b0});
        send(1'b1, 8'h07, 1, 1'b1);
        wait_clks(BIT_CLK);
        q_p.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b1});
        send(1'b1, 8'h07, 0, 1'b1);
        wait_clks(BIT_CLK);
        check("parity_valid_count", 32'(n_valid_p), 32'd2);

        // Reset in the middle of a frame (after data bit 3)
        base = n_valid_a;
        drive(1'b0, 1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'(8'h96 >> i), BIT_CLK);
        check("midframe_busy", 32'(rx_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_busy", 32'(rx_busy), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_parity_err_p", 32'(parity_err_p), 32'h0);
        check("rst_rx_data_p", 32'(rx_data_p), 32'h0);
        wait_clks(3);
        rx = 1'b1;
        rst_n = 1'b1;
        wait_clks(2 * BIT_CLK);
        check("rst_no_valid", 32'(n_valid_a - base), 32'd0);
        q_a.push_back('{data: 8'h5A, ferr: 1'b0, perr: 1'b0});
        send(1'b0, 8'h5A, -1, 1'b1);
        wait_clks(BIT_CLK);

        // Back-to-back frames, one stop bit each
        base = n_valid_a;
        q_a.push_back('{data: 8'h00, ferr: 1'b0, perr: 1'b0});
        send(1'b0, 8'h00, -1, 1'b1);
        q_a.push_back('{data: 8'hFF, ferr: 1'b0, perr: 1'b0});
        send(1'b0, 8'hFF, -1, 1'b1);
        wait_clks(2 * BIT_CLK);
        check("b2b_valid_count", 32'(n_valid_a - base), 32'd2);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("p_queue_drained", 32'(q_p.size()), 32'd0);
        check("a_total_frames", 32'(n_valid_a), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
